// File: rtl/controlador_barrido_teclado_pkg.sv
// Shared types and widths for the hex keypad scan controller.
package teclado_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SCAN,
        DEBOUNCE,
        WAIT_RELEASE,
        REL_DEBOUNCE
    } estado_t;

    localparam int COL_W  = 2;
    localparam int FILA_W = 4;
    localparam int CODE_W = 4;

endpackage

// File: rtl/controlador_barrido_teclado_if.sv
// Consumer-side key handshake: captured code, valid/ready, and the sticky overrun flag with its clear.
interface controlador_barrido_teclado_if;
    import teclado_pkg::*;

    logic [CODE_W-1:0] dato_o;
    logic              valid_o;
    logic              ready_i;
    logic              overrun_o;
    logic              clear_i;

    modport master (
        output dato_o,
        output valid_o,
        output overrun_o,
        input  ready_i,
        input  clear_i
    );

    modport slave (
        input  dato_o,
        input  valid_o,
        input  overrun_o,
        output ready_i,
        output clear_i
    );

endinterface

// File: rtl/controlador_barrido_teclado_contador_estable.sv
// Stable-sample counter: done pulses on the DEBOUNCE_CYCLES-th consecutive matching edge after restart.
module contador_estable #(
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic clk_i,
    input  logic reset_i,
    input  logic restart,
    input  logic match,
    output logic done
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES) + 1;
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [CNT_W-1:0] cnt;

    // Saturates at DEBOUNCE_CYCLES; any mismatch throws the run away.
    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            cnt <= '0;
        end else if (restart || !match) begin
            cnt <= '0;
        end else if (cnt != CNT_MAX) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    assign done = match && !restart && (cnt == CNT_LAST);

endmodule

// File: rtl/controlador_barrido_teclado.sv
// Keypad scan sequencer: walks the columns, debounces press and release, and hands one raw code
// {row index, column} per keystroke to the consumer over valid/ready.
module controlador_barrido_teclado
    import teclado_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES  = 16,
    parameter int SCAN_HOLD_CYCLES = 4
) (
    input  logic                          clk_i,
    input  logic                          reset_i,
    input  logic                          enable_i,
    input  logic [FILA_W-1:0]             fila_i,
    output logic [COL_W-1:0]              columna_o,
    output logic                          busy_o,
    controlador_barrido_teclado_if.master bus
);

    localparam int HOLD_W = $clog2(SCAN_HOLD_CYCLES) + 1;
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(SCAN_HOLD_CYCLES - 1);

    estado_t             estado;
    logic [HOLD_W-1:0]   hold_cnt;
    logic [FILA_W-1:0]   snapshot;
    logic [COL_W-1:0]    columna;
    logic [CODE_W-1:0]   dato;
    logic                valid;
    logic                overrun;
    logic                busy;

    logic                fila_act;
    logic                deb_restart;
    logic                deb_match;
    logic                deb_done;
    logic                captura;
    logic                acepta;

    // Lowest set row wins when several rows read high at once.
    function automatic logic [1:0] fila_idx(input logic [FILA_W-1:0] f);
        if (f[0])      return 2'd0;
        else if (f[1]) return 2'd1;
        else if (f[2]) return 2'd2;
        else           return 2'd3;
    endfunction

    assign fila_act    = |fila_i;
    assign deb_restart = !enable_i || !((estado == DEBOUNCE) || (estado == REL_DEBOUNCE));
    assign deb_match   = (estado == DEBOUNCE) ? (fila_i == snapshot) : !fila_act;
    assign captura     = enable_i && (estado == DEBOUNCE) && deb_done;
    assign acepta      = valid && bus.ready_i;

    contador_estable #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_contador_estable (
        .clk_i  (clk_i),
        .reset_i(reset_i),
        .restart(deb_restart),
        .match  (deb_match),
        .done   (deb_done)
    );

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            estado   <= IDLE;
            hold_cnt <= '0;
            snapshot <= '0;
            columna  <= '0;
            dato     <= '0;
            valid    <= 1'b0;
            overrun  <= 1'b0;
            busy     <= 1'b0;
        end else begin
            if (!enable_i) begin
                estado   <= IDLE;
                hold_cnt <= '0;
                busy     <= 1'b0;
            end else begin
                case (estado)
                    IDLE: begin
                        estado   <= SCAN;
                        hold_cnt <= '0;
                    end
                    SCAN: begin
                        if (fila_act) begin
                            estado   <= DEBOUNCE;
                            snapshot <= fila_i;
                            busy     <= 1'b1;
                        end else if (hold_cnt == HOLD_LAST) begin
                            columna  <= columna + COL_W'(1);
                            hold_cnt <= '0;
                        end else begin
                            hold_cnt <= hold_cnt + HOLD_W'(1);
                        end
                    end
                    DEBOUNCE: begin
                        if (fila_i != snapshot) begin
                            estado   <= SCAN;
                            hold_cnt <= '0;
                            busy     <= 1'b0;
                        end else if (deb_done) begin
                            estado <= WAIT_RELEASE;
                        end
                    end
                    WAIT_RELEASE: begin
                        if (!fila_act) estado <= REL_DEBOUNCE;
                    end
                    REL_DEBOUNCE: begin
                        if (fila_act) begin
                            estado <= WAIT_RELEASE;
                        end else if (deb_done) begin
                            estado   <= SCAN;
                            columna  <= columna + COL_W'(1);
                            hold_cnt <= '0;
                            busy     <= 1'b0;
                        end
                    end
                    default: begin
                        estado <= IDLE;
                        busy   <= 1'b0;
                    end
                endcase
            end

            // A capture landing on an accept edge replaces the consumed code instead of clearing valid.
            if (captura && (!valid || bus.ready_i)) begin
                dato  <= {fila_idx(snapshot), columna};
                valid <= 1'b1;
            end else if (acepta) begin
                valid <= 1'b0;
            end

            if (captura && valid && !bus.ready_i) begin
                overrun <= 1'b1;
            end else if (bus.clear_i) begin
                overrun <= 1'b0;
            end
        end
    end

    assign columna_o     = columna;
    assign busy_o        = busy;
    assign bus.dato_o    = dato;
    assign bus.valid_o   = valid;
    assign bus.overrun_o = overrun;

endmodule

// File: tb/tb_controlador_barrido_teclado.sv
// Bench for the keypad scan controller: randomized keystrokes against timing and code rules.
module tb_controlador_barrido_teclado;
    import teclado_pkg::*;

    localparam int DEB  = 16;
    localparam int HOLD = 4;

    logic       clk      = 1'b0;
    logic       reset_i  = 1'b1;
    logic       enable_i = 1'b0;
    logic [3:0] fila_i   = 4'b0;
    logic [1:0] columna_o;
    logic       busy_o;

    int cmp  = 0;
    int errs = 0;

    controlador_barrido_teclado_if bus ();

    controlador_barrido_teclado #(
        .DEBOUNCE_CYCLES (DEB),
        .SCAN_HOLD_CYCLES(HOLD)
    ) dut (
        .clk_i    (clk),
        .reset_i  (reset_i),
        .enable_i (enable_i),
        .fila_i   (fila_i),
        .columna_o(columna_o),
        .busy_o   (busy_o),
        .bus      (bus)
    );

    always #5 clk = ~clk;

    // Reference: row index is the lowest set bit, column is whatever column was selected at detection.
    function automatic logic [3:0] ref_code(input logic [3:0] pat, input logic [1:0] col);
        int r = 3;
        for (int i = 3; i >= 0; i--) if (pat[i]) r = i;
        return {r[1:0], col};
    endfunction

    task automatic wait_col(input logic [1:0] c);
        bit ok = 0;
        for (int i = 0; i < 40 && !ok; i++) begin
            @(negedge clk);
            if (columna_o === c) ok = 1;
        end
        cmp++;
        if (!ok) begin
            errs++;
            $display("FAIL wait_col got %0d want %0d (timeout)", columna_o, c);
        end
    endtask

    // One full keystroke: press held 20 cycles, then released long enough to finish release debounce.
    task automatic keystroke(input logic [1:0] c, input logic [3:0] pat);
        wait_col(c);
        fila_i = pat;
        repeat (20) @(negedge clk);
        fila_i = 4'b0;
        repeat (DEB + 2) @(negedge clk);
    endtask

    task automatic test_reset();
        reset_i = 1'b1;
        #1 reset_i = 1'b0;
        repeat (3) @(negedge clk);
        cmp += 5;
        if (columna_o !== 2'd0)    begin errs++; $display("FAIL reset_col got %0d want 0", columna_o); end
        if (bus.dato_o !== 4'd0)   begin errs++; $display("FAIL reset_dato got %0h want 0", bus.dato_o); end
        if (bus.valid_o !== 1'b0)  begin errs++; $display("FAIL reset_valid got %0b want 0", bus.valid_o); end
        if (bus.overrun_o !== 1'b0) begin errs++; $display("FAIL reset_overrun got %0b want 0", bus.overrun_o); end
        if (busy_o !== 1'b0)       begin errs++; $display("FAIL reset_busy got %0b want 0", busy_o); end
        reset_i = 1'b1;
        repeat (6) @(negedge clk);
        cmp++;
        if (columna_o !== 2'd0) begin errs++; $display("FAIL idle_hold_col got %0d want 0", columna_o); end
    endtask

    task automatic test_scan();
        logic [1:0] exp;
        enable_i = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            exp = 2'((i / HOLD) % 4);
            cmp++;
            if (columna_o !== exp) begin errs++; $display("FAIL scan_col[%0d] got %0d want %0d", i, columna_o, exp); end
        end
        cmp++;
        if (busy_o !== 1'b0) begin errs++; $display("FAIL scan_busy got %0b want 0", busy_o); end
    endtask

    task automatic test_press();
        logic [1:0] c;
        logic [3:0] pat, exp;
        for (int it = 0; it < 3; it++) begin
            c   = (it == 0) ? 2'd2 : 2'($urandom_range(0, 3));
            pat = (it == 0) ? 4'b0110 : 4'($urandom_range(1, 15));
            exp = ref_code(pat, c);
            wait_col(c);
            fila_i = pat;
            for (int j = 0; j < 20; j++) begin
                @(negedge clk);
                if (j == 0) begin
                    cmp++;
                    if (busy_o !== 1'b1) begin errs++; $display("FAIL press_busy got %0b want 1", busy_o); end
                end
                if (j == DEB - 1) begin
                    cmp++;
                    if (bus.valid_o !== 1'b0) begin errs++; $display("FAIL press_early_valid got %0b want 0", bus.valid_o); end
                end
                if (j == DEB) begin
                    cmp += 2;
                    if (bus.valid_o !== 1'b1) begin errs++; $display("FAIL press_valid got %0b want 1", bus.valid_o); end
                    if (bus.dato_o !== exp)   begin errs++; $display("FAIL press_dato got %0h want %0h", bus.dato_o, exp); end
                end
            end
            fila_i = 4'b0;
            for (int k = 0; k <= DEB; k++) begin
                @(negedge clk);
                if (k == 0) begin
                    cmp += 2;
                    if (bus.valid_o !== 1'b1) begin errs++; $display("FAIL hold_valid got %0b want 1", bus.valid_o); end
                    if (bus.dato_o !== exp)   begin errs++; $display("FAIL hold_dato got %0h want %0h", bus.dato_o, exp); end
                end
                if (k == DEB - 1) begin
                    cmp++;
                    if (busy_o !== 1'b1) begin errs++; $display("FAIL rel_busy got %0b want 1", busy_o); end
                end
                if (k == DEB) begin
                    cmp += 2;
                    if (busy_o !== 1'b0) begin errs++; $display("FAIL rel_done_busy got %0b want 0", busy_o); end
                    if (columna_o !== c + 2'd1) begin errs++; $display("FAIL rel_col got %0d want %0d", columna_o, c + 2'd1); end
                end
            end
            bus.ready_i = 1'b1;
            @(negedge clk);
            bus.ready_i = 1'b0;
            cmp++;
            if (bus.valid_o !== 1'b0) begin errs++; $display("FAIL accept_valid got %0b want 0", bus.valid_o); end
        end
    endtask

    task automatic test_bounce();
        logic [1:0] c;
        int n;
        for (int it = 0; it < 3; it++) begin
            c = 2'($urandom_range(0, 3));
            n = (it == 0) ? 5 : $urandom_range(1, DEB - 1);
            wait_col(c);
            fila_i = (it == 0) ? 4'b0001 : 4'($urandom_range(1, 15));
            repeat (n) @(negedge clk);
            cmp++;
            if (busy_o !== 1'b1) begin errs++; $display("FAIL bounce_busy got %0b want 1", busy_o); end
            fila_i = 4'b0;
            @(negedge clk);
            cmp += 2;
            if (busy_o !== 1'b0)  begin errs++; $display("FAIL bounce_idle got %0b want 0", busy_o); end
            if (columna_o !== c)  begin errs++; $display("FAIL bounce_col got %0d want %0d", columna_o, c); end
            repeat (HOLD - 1) @(negedge clk);
            cmp++;
            if (columna_o !== c)  begin errs++; $display("FAIL bounce_hold got %0d want %0d", columna_o, c); end
            @(negedge clk);
            cmp += 2;
            if (columna_o !== c + 2'd1) begin errs++; $display("FAIL bounce_adv got %0d want %0d", columna_o, c + 2'd1); end
            if (bus.valid_o !== 1'b0)   begin errs++; $display("FAIL bounce_valid got %0b want 0", bus.valid_o); end
        end
    endtask

    task automatic test_overrun(output logic [3:0] first);
        logic [1:0] c1, c2, c3;
        logic [3:0] p1, p2, p3;
        c1 = 2'($urandom_range(0, 3)); p1 = 4'($urandom_range(1, 15));
        c2 = 2'($urandom_range(0, 3)); p2 = 4'($urandom_range(1, 15));
        c3 = 2'($urandom_range(0, 3)); p3 = 4'($urandom_range(1, 15));
        first = ref_code(p1, c1);
        keystroke(c1, p1);
        keystroke(c2, p2);
        cmp += 3;
        if (bus.valid_o !== 1'b1)   begin errs++; $display("FAIL ovr_valid got %0b want 1", bus.valid_o); end
        if (bus.dato_o !== first)   begin errs++; $display("FAIL ovr_dato got %0h want %0h", bus.dato_o, first); end
        if (bus.overrun_o !== 1'b1) begin errs++; $display("FAIL ovr_flag got %0b want 1", bus.overrun_o); end
        bus.clear_i = 1'b1;
        @(negedge clk);
        bus.clear_i = 1'b0;
        cmp += 2;
        if (bus.overrun_o !== 1'b0) begin errs++; $display("FAIL ovr_clear got %0b want 0", bus.overrun_o); end
        if (bus.dato_o !== first)   begin errs++; $display("FAIL ovr_clear_dato got %0h want %0h", bus.dato_o, first); end
        // Clear coincides with the dropped capture: the drop must still be flagged.
        wait_col(c3);
        fila_i = p3;
        repeat (DEB) @(negedge clk);
        bus.clear_i = 1'b1;
        @(negedge clk);
        bus.clear_i = 1'b0;
        cmp += 2;
        if (bus.overrun_o !== 1'b1) begin errs++; $display("FAIL ovr_set_wins got %0b want 1", bus.overrun_o); end
        if (bus.dato_o !== first)   begin errs++; $display("FAIL ovr_keep_dato got %0h want %0h", bus.dato_o, first); end
        repeat (4) @(negedge clk);
        fila_i = 4'b0;
        repeat (DEB + 2) @(negedge clk);
        bus.clear_i = 1'b1;
        @(negedge clk);
        bus.clear_i = 1'b0;
    endtask

    task automatic test_back_to_back(input logic [3:0] pending);
        logic [1:0] c;
        logic [3:0] pat, exp;
        c   = 2'($urandom_range(0, 3));
        pat = 4'($urandom_range(1, 15));
        exp = ref_code(pat, c);
        wait_col(c);
        fila_i = pat;
        repeat (DEB) @(negedge clk);
        cmp += 2;
        if (bus.valid_o !== 1'b1) begin errs++; $display("FAIL b2b_pending got %0b want 1", bus.valid_o); end
        if (bus.dato_o !== pending) begin errs++; $display("FAIL b2b_old got %0h want %0h", bus.dato_o, pending); end
        bus.ready_i = 1'b1;
        @(negedge clk);
        bus.ready_i = 1'b0;
        cmp += 3;
        if (bus.valid_o !== 1'b1)   begin errs++; $display("FAIL b2b_valid got %0b want 1", bus.valid_o); end
        if (bus.dato_o !== exp)     begin errs++; $display("FAIL b2b_dato got %0h want %0h", bus.dato_o, exp); end
        if (bus.overrun_o !== 1'b0) begin errs++; $display("FAIL b2b_overrun got %0b want 0", bus.overrun_o); end
        repeat (3) @(negedge clk);
        fila_i = 4'b0;
        repeat (DEB + 2) @(negedge clk);
    endtask

    task automatic test_enable_abort();
        logic [1:0] c;
        bus.ready_i = 1'b1;
        @(negedge clk);
        bus.ready_i = 1'b0;
        c = 2'($urandom_range(0, 3));
        wait_col(c);
        fila_i = 4'($urandom_range(1, 15));
        repeat (5) @(negedge clk);
        enable_i = 1'b0;
        @(negedge clk);
        cmp += 2;
        if (busy_o !== 1'b0) begin errs++; $display("FAIL abort_busy got %0b want 0", busy_o); end
        if (columna_o !== c) begin errs++; $display("FAIL abort_col got %0d want %0d", columna_o, c); end
        repeat (DEB + 4) @(negedge clk);
        cmp += 2;
        if (bus.valid_o !== 1'b0) begin errs++; $display("FAIL abort_valid got %0b want 0", bus.valid_o); end
        if (columna_o !== c)      begin errs++; $display("FAIL abort_hold got %0d want %0d", columna_o, c); end
        fila_i = 4'b0;
        enable_i = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_async_reset();
        logic [1:0] c;
        keystroke(2'($urandom_range(0, 3)), 4'($urandom_range(1, 15)));
        keystroke(2'($urandom_range(0, 3)), 4'($urandom_range(1, 15)));
        c = 2'($urandom_range(1, 3));
        wait_col(c);
        fila_i = 4'($urandom_range(1, 15));
        repeat (5) @(negedge clk);
        cmp += 2;
        if (bus.overrun_o !== 1'b1) begin errs++; $display("FAIL pre_reset_overrun got %0b want 1", bus.overrun_o); end
        if (busy_o !== 1'b1)        begin errs++; $display("FAIL pre_reset_busy got %0b want 1", busy_o); end
        @(posedge clk);
        #2 reset_i = 1'b0;
        enable_i = 1'b0;
        #1;
        cmp += 5;
        if (columna_o !== 2'd0)     begin errs++; $display("FAIL areset_col got %0d want 0", columna_o); end
        if (bus.dato_o !== 4'd0)    begin errs++; $display("FAIL areset_dato got %0h want 0", bus.dato_o); end
        if (bus.valid_o !== 1'b0)   begin errs++; $display("FAIL areset_valid got %0b want 0", bus.valid_o); end
        if (bus.overrun_o !== 1'b0) begin errs++; $display("FAIL areset_overrun got %0b want 0", bus.overrun_o); end
        if (busy_o !== 1'b0)        begin errs++; $display("FAIL areset_busy got %0b want 0", busy_o); end
        fila_i = 4'b0;
        @(negedge clk);
        reset_i = 1'b1;
        repeat (6) @(negedge clk);
        cmp++;
        if (columna_o !== 2'd0) begin errs++; $display("FAIL post_reset_idle got %0d want 0", columna_o); end
        enable_i = 1'b1;
        for (int i = 0; i <= HOLD; i++) begin
            @(negedge clk);
            if (i == HOLD - 1 || i == HOLD) begin
                cmp++;
                if (columna_o !== 2'(i / HOLD)) begin
                    errs++;
                    $display("FAIL post_reset_scan[%0d] got %0d want %0d", i, columna_o, i / HOLD);
                end
            end
        end
    endtask

    initial begin
        logic [3:0] pending;
        bus.ready_i = 1'b0;
        bus.clear_i = 1'b0;
        test_reset();
        test_scan();
        test_press();
        test_bounce();
        test_overrun(pending);
        test_back_to_back(pending);
        test_enable_abort();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, errs);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog got timeout want completion");
        $fatal(1, "watchdog");
    end

endmodule
